// File: rtl/mmc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mmc_ctrl_pkg
// Shared types for the multi-mode-counter session arbiter.
//   mode_e   : counter mode codes (up by 1/2, down by 1/2)
//   state_e  : session FSM states
//   result_e : result codes reported alongside done
// ---------------------------------------------------------------------------
package mmc_ctrl_pkg;

  typedef enum logic [1:0] {
    UP1   = 2'b00,
    UP2   = 2'b01,
    DOWN1 = 2'b10,
    DOWN2 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    RUN    = 2'b10,
    REPORT = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE    = 2'b00,
    RES_LOSE    = 2'b01,
    RES_WIN     = 2'b10,
    RES_TIMEOUT = 2'b11
  } result_e;

endpackage

// File: rtl/mmc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mmc_rr_arbiter
// N_REQ-wide round-robin arbiter. The grant is combinational from req and
// the priority pointer; the pointer only moves when update is pulsed, and
// then points just past the requester given in upd_gnt.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector
//   update     : advance the pointer past upd_gnt this cycle
//   upd_gnt    : one-hot requester whose session just ended
//   gnt        : one-hot winner of the current search (0 when no req)
//   any_req    : at least one request present
// ---------------------------------------------------------------------------
module mmc_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             update,
  input  logic [N_REQ-1:0] upd_gnt,
  output logic [N_REQ-1:0] gnt,
  output logic             any_req
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    ptr_reg;
  logic [PW-1:0]    ptr_next;
  logic [N_REQ-1:0] rot_req;
  logic [N_REQ-1:0] rot_gnt;

  // Rotate so the pointer position sits at bit 0, take the lowest set bit,
  // then rotate the single grant bit back into place.
  assign rot_req = N_REQ'({req, req} >> ptr_reg);
  assign rot_gnt = rot_req & (~rot_req + N_REQ'(1));
  assign gnt     = N_REQ'(({rot_gnt, rot_gnt} << ptr_reg) >> N_REQ);
  assign any_req = |req;

  always_comb begin
    ptr_next = ptr_reg;
    if (update) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (upd_gnt[k]) begin
          ptr_next = (k == N_REQ - 1) ? '0 : PW'(k + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/mmc_session_arbiter.sv
// ---------------------------------------------------------------------------
// mmc_session_arbiter
// Shares one multi-mode counter between N_REQ requesters. Each session:
// grant one requester (round robin), load its mode/initial value into the
// counter, count rising edges of cnt_winner / cnt_loser, and after ROUNDS
// events of one kind pulse done to the granted requester with the result.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req[N]            level session request per requester
//   req_mode[2N]      per-requester mode (00 up1, 01 up2, 10 down1, 11 down2)
//   req_value[W*N]    per-requester initial counter value
//   gnt[N]            one-hot grant, held LOAD..REPORT
//   done[N]           one-cycle pulse to the granted requester at session end
//   result[2]         valid with done: 10 winner, 01 loser, 11 timeout
//   cnt_rst           active-high counter reset (high outside a session)
//   cnt_init          one-cycle load strobe to the counter
//   cnt_mode[2]       mode to the counter, held for the session
//   cnt_value[W]      initial value to the counter
//   cnt_winner        counter at max value
//   cnt_loser         counter at zero
//
// Build option: define MMC_CTRL_TIMEOUT_EN to add a RUN-state watchdog that
// ends the session with result 11 after TIMEOUT_CYCLES RUN cycles.
// Without it there is no watchdog and TIMEOUT_CYCLES has no effect.
// ---------------------------------------------------------------------------
module mmc_session_arbiter
  import mmc_ctrl_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int CNT_WIDTH      = 4,
  parameter int ROUNDS         = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [2*N_REQ-1:0]         req_mode,
  input  logic [CNT_WIDTH*N_REQ-1:0] req_value,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic [1:0]                 result,
  output logic                       cnt_rst,
  output logic                       cnt_init,
  output logic [1:0]                 cnt_mode,
  output logic [CNT_WIDTH-1:0]       cnt_value,
  input  logic                       cnt_winner,
  input  logic                       cnt_loser
);

  localparam int            TW        = $clog2(ROUNDS + 1);
  localparam logic [TW-1:0] TALLY_END = TW'(ROUNDS);
  localparam logic [TW-1:0] TALLY_MAX = '1;

  // -------------------------------------------------------------------------
  // Registered state and outputs
  // -------------------------------------------------------------------------
  state_e               state_reg;
  logic [N_REQ-1:0]     gnt_reg;
  logic [N_REQ-1:0]     done_reg;
  result_e              result_reg;
  logic                 cnt_rst_reg;
  logic                 cnt_init_reg;
  mode_e                mode_reg;
  logic [CNT_WIDTH-1:0] value_reg;
  logic [TW-1:0]        win_tally_reg;
  logic [TW-1:0]        lose_tally_reg;
  logic                 win_q_reg;
  logic                 lose_q_reg;

  // -------------------------------------------------------------------------
  // Request unpacking and selection of the winner's mode/value
  // -------------------------------------------------------------------------
  logic [1:0]           mode_arr  [N_REQ];
  logic [CNT_WIDTH-1:0] value_arr [N_REQ];
  logic [1:0]           sel_mode;
  logic [CNT_WIDTH-1:0] sel_value;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign mode_arr[gi]  = req_mode[2*gi +: 2];
      assign value_arr[gi] = req_value[CNT_WIDTH*gi +: CNT_WIDTH];
    end
  endgenerate

  logic [N_REQ-1:0] arb_gnt;
  logic             arb_any;
  logic             arb_update;
  logic             granted_live;

  always_comb begin
    sel_mode  = '0;
    sel_value = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_gnt[k]) begin
        sel_mode  = mode_arr[k];
        sel_value = value_arr[k];
      end
    end
  end

  // Session is still wanted only while the granted requester holds req.
  assign granted_live = |(req & gnt_reg);

  // Pointer moves when a session leaves REPORT or is aborted in LOAD/RUN.
  assign arb_update = (state_reg == REPORT) ||
                      (((state_reg == LOAD) || (state_reg == RUN)) && !granted_live);

  mmc_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .update  (arb_update),
    .upd_gnt (gnt_reg),
    .gnt     (arb_gnt),
    .any_req (arb_any)
  );

  // -------------------------------------------------------------------------
  // Event detection and tallies
  // -------------------------------------------------------------------------
  logic          win_rise;
  logic          lose_rise;
  logic          win_count;
  logic [TW-1:0] win_tally_next;
  logic [TW-1:0] lose_tally_next;
  logic          win_end;
  logic          lose_end;

  assign win_rise  = cnt_winner & ~win_q_reg;
  assign lose_rise = cnt_loser & ~lose_q_reg;
  // When both edges land together only the loser counts; the winner edge is
  // consumed (its copy still updates) and never counted.
  assign win_count = win_rise & ~lose_rise;

  assign lose_tally_next = (lose_rise && (lose_tally_reg != TALLY_MAX)) ?
                           lose_tally_reg + TW'(1) : lose_tally_reg;
  assign win_tally_next  = (win_count && (win_tally_reg != TALLY_MAX)) ?
                           win_tally_reg + TW'(1) : win_tally_reg;

  assign lose_end = (lose_tally_next == TALLY_END);
  assign win_end  = (win_tally_next == TALLY_END);

  // -------------------------------------------------------------------------
  // Optional RUN watchdog
  // -------------------------------------------------------------------------
  logic timeout_hit;

`ifdef MMC_CTRL_TIMEOUT_EN
  localparam int             TMW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMW-1:0] TIMER_END = TMW'(TIMEOUT_CYCLES);

  logic [TMW-1:0] timer_reg;
  logic [TMW-1:0] timer_next;

  // timer_next counts the RUN cycle in progress, so the session ends on the
  // edge closing the TIMEOUT_CYCLES-th RUN cycle.
  assign timer_next  = timer_reg + TMW'(1);
  assign timeout_hit = (timer_next == TIMER_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
    end else if (state_reg == LOAD) begin
      timer_reg <= '0;
    end else if (state_reg == RUN) begin
      timer_reg <= timer_next;
    end
  end
`else
  assign timeout_hit = 1'b0;

  // Keeps TIMEOUT_CYCLES referenced in builds without the watchdog.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  // -------------------------------------------------------------------------
  // Session FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      gnt_reg        <= '0;
      done_reg       <= '0;
      result_reg     <= RES_NONE;
      cnt_rst_reg    <= 1'b1;
      cnt_init_reg   <= 1'b0;
      mode_reg       <= UP1;
      value_reg      <= '0;
      win_tally_reg  <= '0;
      lose_tally_reg <= '0;
      win_q_reg      <= 1'b0;
      lose_q_reg     <= 1'b0;
    end else begin
      done_reg     <= '0;
      cnt_init_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_rst_reg <= 1'b1;
          if (arb_any) begin
            gnt_reg      <= arb_gnt;
            mode_reg     <= mode_e'(sel_mode);
            value_reg    <= sel_value;
            cnt_rst_reg  <= 1'b0;
            cnt_init_reg <= 1'b1;
            state_reg    <= LOAD;
          end
        end

        LOAD: begin
          win_tally_reg  <= '0;
          lose_tally_reg <= '0;
          win_q_reg      <= 1'b0;
          lose_q_reg     <= 1'b0;
          if (!granted_live) begin
            gnt_reg     <= '0;
            cnt_rst_reg <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            state_reg <= RUN;
          end
        end

        RUN: begin
          if (!granted_live) begin
            gnt_reg     <= '0;
            cnt_rst_reg <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            win_q_reg      <= cnt_winner;
            lose_q_reg     <= cnt_loser;
            win_tally_reg  <= win_tally_next;
            lose_tally_reg <= lose_tally_next;
            if (lose_end || win_end || timeout_hit) begin
              done_reg    <= gnt_reg;
              cnt_rst_reg <= 1'b1;
              state_reg   <= REPORT;
              if (lose_end) begin
                result_reg <= RES_LOSE;
              end else if (win_end) begin
                result_reg <= RES_WIN;
              end else begin
                result_reg <= RES_TIMEOUT;
              end
            end
          end
        end

        REPORT: begin
          gnt_reg    <= '0;
          result_reg <= RES_NONE;
          state_reg  <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign done      = done_reg;
  assign result    = result_reg;
  assign cnt_rst   = cnt_rst_reg;
  assign cnt_init  = cnt_init_reg;
  assign cnt_mode  = mode_reg;
  assign cnt_value = value_reg;

endmodule
